// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard
// Per-register pending-result scoreboard for an in-order pipeline. Every
// architectural register except r0 has a small down-counter that holds the
// number of cycles until its in-flight result can be consumed. The ID-stage
// instruction is held while any source it reads is pending, or while its
// destination would still be overwritten later by an older in-flight writer.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   id_valid            a valid instruction sits in ID
//   id_rs / id_rt       source indices, qualified by id_rs_used / id_rt_used
//   id_wr_en / id_rd    destination write enable and index
//   id_lat              cycles until the result is forwardable (0 = next cycle)
//   flush               squash the ID instruction
//   stall               hold the ID instruction
//   pc_write_en         PC update enable (!stall)
//   ifid_write_en       IF/ID enable (!stall)
//   idex_bubble         insert NOP into ID/EX (stall || flush)
//   pending_cnt         number of registers with a nonzero counter
//
// NREG must equal 2**AW.
module hazard_scoreboard #(
    parameter int NREG     = 32,
    parameter int AW       = 5,
    parameter int LATW     = 3,
    parameter int FWD_EN   = 1,
    parameter int WB_EXTRA = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            id_valid,
    input  logic [AW-1:0]   id_rs,
    input  logic [AW-1:0]   id_rt,
    input  logic            id_rs_used,
    input  logic            id_rt_used,
    input  logic            id_wr_en,
    input  logic [AW-1:0]   id_rd,
    input  logic [LATW-1:0] id_lat,
    input  logic            flush,
    output logic            stall,
    output logic            pc_write_en,
    output logic            ifid_write_en,
    output logic            idex_bubble,
    output logic [AW:0]     pending_cnt
);

    localparam logic [31:0] LD_MAX = 32'((2 ** LATW) - 1);
    localparam logic [31:0] LD_ADD = (FWD_EN != 0) ? 32'd0 : 32'(WB_EXTRA);

    logic [LATW-1:0] cnt_q [1:NREG-1];
    logic [LATW-1:0] cnt_d [1:NREG-1];

    // Read view with r0 hard-wired to zero so indexing needs no special case.
    logic [LATW-1:0] cnt_view [NREG];

    logic [31:0]     ld_wide;
    logic [LATW-1:0] ld;
    logic            haz_a;
    logic            haz_b;
    logic            waw;
    logic            issue;
    logic            do_load;

    always_comb begin
        cnt_view[0] = '0;
        for (int r = 1; r < NREG; r++) begin
            cnt_view[r] = cnt_q[r];
        end
    end

    // Load value is computed wide so that adding the writeback delay can
    // saturate at the counter maximum instead of wrapping.
    always_comb begin
        ld_wide = 32'(id_lat) + LD_ADD;
        if (ld_wide > LD_MAX) begin
            ld = LD_MAX[LATW-1:0];
        end else begin
            ld = ld_wide[LATW-1:0];
        end
    end

    always_comb begin
        haz_a   = id_rs_used && (id_rs != '0) && (cnt_view[id_rs] != '0);
        haz_b   = id_rt_used && (id_rt != '0) && (cnt_view[id_rt] != '0);
        // WAW: an older writer that finishes after this one would clobber it.
        waw     = id_wr_en && (id_rd != '0) && (cnt_view[id_rd] > ld);
        stall   = id_valid && !flush && (haz_a || haz_b || waw);
        issue   = id_valid && !stall && !flush;
        do_load = issue && id_wr_en && (id_rd != '0) && (ld != '0);
    end

    assign pc_write_en   = !stall;
    assign ifid_write_en = !stall;
    assign idex_bubble   = stall || flush;

    always_comb begin
        for (int r = 1; r < NREG; r++) begin
            if (cnt_q[r] != '0) begin
                cnt_d[r] = cnt_q[r] - 1'b1;
            end else begin
                cnt_d[r] = '0;
            end
            // A new load replaces the entry's own decrement this cycle.
            if (do_load && (id_rd == AW'(r))) begin
                cnt_d[r] = ld;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 1; r < NREG; r++) begin
                cnt_q[r] <= '0;
            end
        end else begin
            for (int r = 1; r < NREG; r++) begin
                cnt_q[r] <= cnt_d[r];
            end
        end
    end

    always_comb begin
        pending_cnt = '0;
        for (int r = 1; r < NREG; r++) begin
            pending_cnt = pending_cnt + (AW + 1)'(cnt_q[r] != '0);
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
module tb_hazard_scoreboard;

    logic       clk;
    logic       rst_n;
    logic       id_valid;
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic       id_rs_used;
    logic       id_rt_used;
    logic       id_wr_en;
    logic [4:0] id_rd;
    logic [2:0] id_lat;
    logic       flush;

    logic       st [2];
    logic       pw [2];
    logic       iw [2];
    logic       bb [2];
    logic [5:0] pc [2];

    int n_checks;
    int n_fail;

    // Reference state: remaining cycles per register, per instance.
    // Instance 0 forwards (FWD_EN=1); instance 1 adds a writeback delay of 2.
    int mc [2][32];

    hazard_scoreboard u_fwd (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
        .id_rs(id_rs), .id_rt(id_rt), .id_rs_used(id_rs_used),
        .id_rt_used(id_rt_used), .id_wr_en(id_wr_en), .id_rd(id_rd),
        .id_lat(id_lat), .flush(flush), .stall(st[0]),
        .pc_write_en(pw[0]), .ifid_write_en(iw[0]),
        .idex_bubble(bb[0]), .pending_cnt(pc[0])
    );

    hazard_scoreboard #(.FWD_EN(0), .WB_EXTRA(2)) u_nofwd (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
        .id_rs(id_rs), .id_rt(id_rt), .id_rs_used(id_rs_used),
        .id_rt_used(id_rt_used), .id_wr_en(id_wr_en), .id_rd(id_rd),
        .id_lat(id_lat), .flush(flush), .stall(st[1]),
        .pc_write_en(pw[1]), .ifid_write_en(iw[1]),
        .idex_bubble(bb[1]), .pending_cnt(pc[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int m_ld(int i);
        int l;
        l = int'(id_lat);
        if (i == 1) l = l + 2;
        if (l > 7) l = 7;
        return l;
    endfunction

    function automatic bit m_stall(int i);
        bit ha, hb, w;
        if (!id_valid || flush) return 1'b0;
        ha = id_rs_used && (id_rs != 0) && (mc[i][id_rs] != 0);
        hb = id_rt_used && (id_rt != 0) && (mc[i][id_rt] != 0);
        w  = id_wr_en && (id_rd != 0) && (mc[i][id_rd] > m_ld(i));
        return ha || hb || w;
    endfunction

    function automatic int m_pend(int i);
        int n;
        n = 0;
        for (int r = 1; r < 32; r++) if (mc[i][r] != 0) n++;
        return n;
    endfunction

    // Advance one clock: model next state from current inputs, then edge.
    task automatic tick();
        int nx [2][32];
        for (int i = 0; i < 2; i++) begin
            for (int r = 0; r < 32; r++) nx[i][r] = (mc[i][r] > 0) ? mc[i][r] - 1 : 0;
            if (id_valid && !flush && !m_stall(i) && id_wr_en && id_rd != 0 && m_ld(i) != 0)
                nx[i][id_rd] = m_ld(i);
        end
        @(posedge clk);
        mc = nx;
        @(negedge clk);
    endtask

    task automatic set_in(input bit v, input int rs, input bit rsu, input int rt, input bit rtu,
                          input bit wr, input int rd, input int lat, input bit fl);
        id_valid   = v;
        id_rs      = 5'(rs);
        id_rs_used = rsu;
        id_rt      = 5'(rt);
        id_rt_used = rtu;
        id_wr_en   = wr;
        id_rd      = 5'(rd);
        id_lat     = 3'(lat);
        flush      = fl;
        #1;
    endtask

    task automatic idle(input int n);
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (n) tick();
    endtask

    task automatic model_clear();
        for (int i = 0; i < 2; i++) for (int r = 0; r < 32; r++) mc[i][r] = 0;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            n_checks++;
            if (st[i] !== 1'b0 || pw[i] !== 1'b1 || iw[i] !== 1'b1 || bb[i] !== 1'b0 || pc[i] !== 6'd0) begin
                n_fail++;
                $display("FAIL reset_values inst%0d: got st=%b pw=%b iw=%b bb=%b pc=%0d exp 0 1 1 0 0",
                         i, st[i], pw[i], iw[i], bb[i], pc[i]);
            end
        end
        flush = 1'b1;
        #1;
        n_checks++;
        if (bb[0] !== 1'b1 || st[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_flush_bubble: got bb=%b st=%b exp bb=1 st=0", bb[0], st[0]);
        end
        flush = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_checks++;
        if (pc[0] !== 6'd0 || st[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: got pc=%0d st=%b exp 0 0", pc[0], st[0]);
        end
        @(negedge clk);
    endtask

    task automatic test_load_use();
        set_in(1, 0, 0, 0, 0, 1, 5, 1, 0);
        n_checks++;
        if (st[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL load_use_issue: got stall=%b exp 0", st[0]);
        end
        tick();
        set_in(1, 5, 1, 0, 0, 0, 0, 0, 0);
        n_checks++;
        if (st[0] !== 1'b1 || pw[0] !== 1'b0 || iw[0] !== 1'b0 || bb[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL load_use_stall: got st=%b pw=%b iw=%b bb=%b exp 1 0 0 1", st[0], pw[0], iw[0], bb[0]);
        end
        tick();
        n_checks++;
        if (st[0] !== 1'b0 || pw[0] !== 1'b1 || bb[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL load_use_release: got st=%b pw=%b bb=%b exp 0 1 0", st[0], pw[0], bb[0]);
        end
        idle(8);
    endtask

    task automatic test_reg_zero();
        set_in(1, 0, 0, 0, 0, 1, 0, 7, 0);
        tick();
        set_in(1, 0, 1, 0, 1, 0, 0, 0, 0);
        n_checks++;
        if (st[0] !== 1'b0 || pc[0] !== 6'd0 || st[1] !== 1'b0 || pc[1] !== 6'd0) begin
            n_fail++;
            $display("FAIL reg_zero: got st=%b/%b pc=%0d/%0d exp 0/0 0/0", st[0], st[1], pc[0], pc[1]);
        end
        idle(1);
    endtask

    task automatic test_saturation();
        int stalls;
        set_in(1, 0, 0, 0, 0, 1, 3, 7, 0);
        tick();
        set_in(1, 0, 0, 3, 1, 0, 0, 0, 0);
        n_checks++;
        if (pc[1] !== 6'd1) begin
            n_fail++;
            $display("FAIL sat_pending: got %0d exp 1", pc[1]);
        end
        stalls = 0;
        for (int k = 0; k < 20; k++) begin
            if (st[1] !== 1'b1) break;
            stalls++;
            tick();
            #1;
        end
        n_checks++;
        if (stalls != 7) begin
            n_fail++;
            $display("FAIL sat_stall_cycles: got %0d exp 7", stalls);
        end
        idle(8);
    endtask

    task automatic test_waw();
        int stalls;
        set_in(1, 0, 0, 0, 0, 1, 4, 5, 0);
        tick();
        set_in(1, 0, 0, 0, 0, 1, 4, 1, 0);
        stalls = 0;
        for (int k = 0; k < 20; k++) begin
            if (st[0] !== 1'b1) break;
            stalls++;
            tick();
            #1;
        end
        // Counter reads 5,4,3,2 while still greater than the new load of 1.
        n_checks++;
        if (stalls != 4) begin
            n_fail++;
            $display("FAIL waw_stall_cycles: got %0d exp 4", stalls);
        end
        tick();
        set_in(1, 4, 1, 0, 0, 0, 0, 0, 0);
        n_checks++;
        if (st[0] !== 1'b1 || pc[0] !== 6'd1) begin
            n_fail++;
            $display("FAIL waw_reload: got st=%b pc=%0d exp 1 1", st[0], pc[0]);
        end
        tick();
        n_checks++;
        if (st[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL waw_release: got %b exp 0", st[0]);
        end
        idle(8);
    endtask

    task automatic test_flush();
        set_in(1, 0, 0, 0, 0, 1, 6, 2, 0);
        tick();
        set_in(1, 6, 1, 0, 0, 1, 7, 3, 1);
        n_checks++;
        if (st[0] !== 1'b0 || bb[0] !== 1'b1 || pw[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_outputs: got st=%b bb=%b pw=%b exp 0 1 1", st[0], bb[0], pw[0]);
        end
        tick();
        set_in(1, 6, 1, 0, 0, 0, 0, 0, 0);
        n_checks++;
        if (st[0] !== 1'b1 || pc[0] !== 6'd1) begin
            n_fail++;
            $display("FAIL flush_no_load: got st=%b pc=%0d exp 1 1", st[0], pc[0]);
        end
        tick();
        n_checks++;
        if (st[0] !== 1'b0 || pc[0] !== 6'd0) begin
            n_fail++;
            $display("FAIL flush_decrement: got st=%b pc=%0d exp 0 0", st[0], pc[0]);
        end
        idle(8);
        set_in(1, 0, 0, 0, 0, 1, 6, 3, 0);
        tick();
        set_in(0, 6, 1, 0, 0, 1, 9, 5, 0);
        n_checks++;
        if (st[0] !== 1'b0 || bb[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL invalid_no_stall: got st=%b bb=%b exp 0 0", st[0], bb[0]);
        end
        repeat (3) tick();
        n_checks++;
        if (pc[0] !== 6'd0) begin
            n_fail++;
            $display("FAIL invalid_decrement: got pc=%0d exp 0", pc[0]);
        end
        idle(8);
    endtask

    task automatic test_reset_mid();
        for (int k = 0; k < 3; k++) begin
            set_in(1, 0, 0, 0, 0, 1, 8 + k, 6, 0);
            tick();
        end
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        n_checks++;
        if (pc[0] !== 6'd3) begin
            n_fail++;
            $display("FAIL mid_pending: got %0d exp 3", pc[0]);
        end
        rst_n = 1'b0;
        model_clear();
        #1;
        n_checks++;
        if (pc[0] !== 6'd0 || pc[1] !== 6'd0) begin
            n_fail++;
            $display("FAIL mid_async_clear: got %0d/%0d exp 0/0", pc[0], pc[1]);
        end
        #1;
        rst_n = 1'b1;
        set_in(1, 8, 1, 9, 1, 0, 0, 0, 0);
        n_checks++;
        if (st[0] !== 1'b0 || st[1] !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_no_residual: got %b/%b exp 0/0", st[0], st[1]);
        end
        tick();
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            set_in(($urandom_range(7) != 0), $urandom_range(7), $urandom_range(1),
                   $urandom_range(7), $urandom_range(1), $urandom_range(1),
                   $urandom_range(7), $urandom_range(7), ($urandom_range(7) == 0));
            for (int i = 0; i < 2; i++) begin
                n_checks++;
                if (st[i] !== m_stall(i) || pw[i] !== !m_stall(i) || iw[i] !== !m_stall(i) ||
                    bb[i] !== (m_stall(i) || flush) || pc[i] !== 6'(m_pend(i))) begin
                    n_fail++;
                    $display("FAIL random inst%0d cyc%0d: got st=%b pw=%b iw=%b bb=%b pc=%0d exp st=%b bb=%b pc=%0d",
                             i, c, st[i], pw[i], iw[i], bb[i], pc[i], m_stall(i),
                             m_stall(i) || flush, m_pend(i));
                end
            end
            tick();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, exp completion");
        $fatal(1, "timeout");
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        model_clear();
        rst_n = 1'b0;
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        test_reset();
        test_load_use();
        test_reg_zero();
        test_saturation();
        test_waw();
        test_flush();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
